// File: rtl/rs_station.sv
// rs_station: reservation-station bank placed after the issue stage.
//   Holds up to DEPTH renamed instructions. Operands that are not yet ready
//   capture their value from the CDB. The oldest entry with both operands
//   ready is dispatched to the functional unit over a valid/ready handshake.
// Ports:
//   clk1, rst (async, active-high), flush (sync clear of all entries)
//   in_*      : issue-side insert (in_valid/in_ready handshake, operand value or tag)
//   cdb_*     : common data bus snoop (valid, tag, data)
//   out_*     : dispatch to the functional unit (out_valid/out_ready handshake)
//   count     : number of busy entries, used by issue for its full check
module rs_station #(
    parameter int DEPTH  = 3,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_func,
    input  logic [TAG_W-1:0]  in_rob,
    input  logic              in_v1_rdy,
    input  logic [DATA_W-1:0] in_v1,
    input  logic [TAG_W-1:0]  in_q1,
    input  logic              in_v2_rdy,
    input  logic [DATA_W-1:0] in_v2,
    input  logic [TAG_W-1:0]  in_q2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_func,
    output logic [TAG_W-1:0]  out_rob,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  r1_q, r1_d;
    logic [DEPTH-1:0]  r2_q, r2_d;
    logic [OP_W-1:0]   func_q [DEPTH];
    logic [OP_W-1:0]   func_d [DEPTH];
    logic [TAG_W-1:0]  rob_q  [DEPTH];
    logic [TAG_W-1:0]  rob_d  [DEPTH];
    logic [DATA_W-1:0] v1_q   [DEPTH];
    logic [DATA_W-1:0] v1_d   [DEPTH];
    logic [DATA_W-1:0] v2_q   [DEPTH];
    logic [DATA_W-1:0] v2_d   [DEPTH];
    logic [TAG_W-1:0]  q1_q   [DEPTH];
    logic [TAG_W-1:0]  q1_d   [DEPTH];
    logic [TAG_W-1:0]  q2_q   [DEPTH];
    logic [TAG_W-1:0]  q2_d   [DEPTH];
    logic [CNT_W-1:0]  age_q  [DEPTH];
    logic [CNT_W-1:0]  age_d  [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DEPTH-1:0]  elig;
    logic [DEPTH-1:0]  sel_oh;
    logic [CNT_W-1:0]  sel_age;
    logic              sel_found;
    logic [DEPTH-1:0]  ins_oh;
    logic              ins_taken;
    logic              do_ins;
    logic              do_disp;
    logic [CNT_W-1:0]  count_after_disp;

    assign count    = count_q;
    assign in_ready = (count_q < DEPTH_C);

    // Selection looks only at registered ready flags, so a CDB capture
    // becomes dispatchable one cycle after the broadcast.
    always_comb begin
        elig      = busy_q & r1_q & r2_q;
        sel_oh    = '0;
        sel_age   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && (!sel_found || (age_q[i] < sel_age))) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_age   = age_q[i];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = sel_found;
        out_func  = '0;
        out_rob   = '0;
        out_a     = '0;
        out_b     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                out_func = func_q[i];
                out_rob  = rob_q[i];
                out_a    = v1_q[i];
                out_b    = v2_q[i];
            end
        end
    end

    // Lowest-index free slot. The slot being dispatched this cycle is still
    // busy here, so it is never chosen for same-cycle refill.
    always_comb begin
        ins_oh    = '0;
        ins_taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_q[i] && !ins_taken) begin
                ins_oh[i] = 1'b1;
                ins_taken = 1'b1;
            end
        end
    end

    always_comb begin
        do_ins           = in_valid && in_ready && !flush;
        do_disp          = out_valid && out_ready && !flush;
        count_after_disp = count_q - CNT_W'(do_disp);

        busy_d = busy_q;
        r1_d   = r1_q;
        r2_d   = r2_q;
        for (int i = 0; i < DEPTH; i++) begin
            func_d[i] = func_q[i];
            rob_d[i]  = rob_q[i];
            v1_d[i]   = v1_q[i];
            v2_d[i]   = v2_q[i];
            q1_d[i]   = q1_q[i];
            q2_d[i]   = q2_q[i];
            age_d[i]  = age_q[i];

            if (busy_q[i] && !r1_q[i] && cdb_valid && (cdb_tag == q1_q[i])) begin
                v1_d[i] = cdb_data;
                r1_d[i] = 1'b1;
            end
            if (busy_q[i] && !r2_q[i] && cdb_valid && (cdb_tag == q2_q[i])) begin
                v2_d[i] = cdb_data;
                r2_d[i] = 1'b1;
            end

            // Ages stay dense: everything younger than the departing entry
            // moves up one place.
            if (do_disp) begin
                if (sel_oh[i]) begin
                    busy_d[i] = 1'b0;
                end else if (busy_q[i] && (age_q[i] > sel_age)) begin
                    age_d[i] = age_q[i] - CNT_W'(1);
                end
            end

            if (do_ins && ins_oh[i]) begin
                busy_d[i] = 1'b1;
                func_d[i] = in_func;
                rob_d[i]  = in_rob;
                q1_d[i]   = in_q1;
                q2_d[i]   = in_q2;
                age_d[i]  = count_after_disp;
                if (in_v1_rdy) begin
                    v1_d[i] = in_v1;
                    r1_d[i] = 1'b1;
                end else if (cdb_valid && (cdb_tag == in_q1)) begin
                    v1_d[i] = cdb_data;
                    r1_d[i] = 1'b1;
                end else begin
                    v1_d[i] = in_v1;
                    r1_d[i] = 1'b0;
                end
                if (in_v2_rdy) begin
                    v2_d[i] = in_v2;
                    r2_d[i] = 1'b1;
                end else if (cdb_valid && (cdb_tag == in_q2)) begin
                    v2_d[i] = cdb_data;
                    r2_d[i] = 1'b1;
                end else begin
                    v2_d[i] = in_v2;
                    r2_d[i] = 1'b0;
                end
            end

            if (flush) begin
                busy_d[i] = 1'b0;
            end
        end

        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(do_ins) - CNT_W'(do_disp);
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i] <= '0;
                rob_q[i]  <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
                q1_q[i]   <= '0;
                q2_q[i]   <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i] <= func_d[i];
                rob_q[i]  <= rob_d[i];
                v1_q[i]   <= v1_d[i];
                v2_q[i]   <= v2_d[i];
                q1_q[i]   <= q1_d[i];
                q2_q[i]   <= q2_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Testbench for rs_station: scoreboard of expected dispatches plus direct
// checks of count, in_ready and the selected entry.
module tb_rs_station;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_func;
    logic [2:0]  in_rob;
    logic        in_v1_rdy;
    logic [15:0] in_v1;
    logic [2:0]  in_q1;
    logic        in_v2_rdy;
    logic [15:0] in_v2;
    logic [2:0]  in_q2;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_func;
    logic [2:0]  out_rob;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [1:0]  count;

    typedef struct packed {
        logic [3:0]  func;
        logic [2:0]  rob;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rs_station dut (
        .clk1      (clk1),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_func   (in_func),
        .in_rob    (in_rob),
        .in_v1_rdy (in_v1_rdy),
        .in_v1     (in_v1),
        .in_q1     (in_q1),
        .in_v2_rdy (in_v2_rdy),
        .in_v2     (in_v2),
        .in_q2     (in_q2),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_func  (out_func),
        .out_rob   (out_rob),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count)
    );

    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic expect_disp(input logic [3:0] f, input logic [2:0] r,
                               input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.func = f;
        e.rob  = r;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    // Holds the instruction for one edge; caller guarantees in_ready.
    task automatic insert(input logic [3:0] f, input logic [2:0] r,
                          input logic v1r, input logic [15:0] v1, input logic [2:0] q1,
                          input logic v2r, input logic [15:0] v2, input logic [2:0] q2);
        in_valid  = 1'b1;
        in_func   = f;
        in_rob    = r;
        in_v1_rdy = v1r;
        in_v1     = v1;
        in_q1     = q1;
        in_v2_rdy = v2r;
        in_v2     = v2;
        in_q2     = q2;
        tick();
        in_valid  = 1'b0;
    endtask

    // Handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk1) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_dispatch_rob", {29'd0, out_rob}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("disp_func", {28'd0, out_func}, {28'd0, e.func});
                check_val("disp_rob",  {29'd0, out_rob},  {29'd0, e.rob});
                check_val("disp_a",    {16'd0, out_a},    {16'd0, e.a});
                check_val("disp_b",    {16'd0, out_b},    {16'd0, e.b});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_func = '0; in_rob = '0;
        in_v1_rdy = 1'b0; in_v1 = '0; in_q1 = '0; in_v2_rdy = 1'b0; in_v2 = '0; in_q2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        check_val("rst_count",     {30'd0, count}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check_val("rst_out_a",     {16'd0, out_a}, 32'd0);

        // Fill with three ready ops, then drain in age order.
        insert(4'd1, 3'd1, 1'b1, 16'h0011, 3'd0, 1'b1, 16'h0012, 3'd0);
        expect_disp(4'd1, 3'd1, 16'h0011, 16'h0012);
        insert(4'd1, 3'd2, 1'b1, 16'h0021, 3'd0, 1'b1, 16'h0022, 3'd0);
        expect_disp(4'd1, 3'd2, 16'h0021, 16'h0022);
        insert(4'd1, 3'd3, 1'b1, 16'h0031, 3'd0, 1'b1, 16'h0032, 3'd0);
        expect_disp(4'd1, 3'd3, 16'h0031, 16'h0032);
        check_val("full_count",    {30'd0, count}, 32'd3);
        check_val("full_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("full_sel_rob",  {29'd0, out_rob}, 32'd1);
        insert(4'd9, 3'd7, 1'b1, 16'h0077, 3'd0, 1'b1, 16'h0078, 3'd0);
        check_val("full_no_write_count", {30'd0, count}, 32'd3);
        out_ready = 1'b1;
        tick();
        check_val("drain1_count", {30'd0, count}, 32'd2);
        tick();
        tick();
        out_ready = 1'b0;
        check_val("drain_count",     {30'd0, count}, 32'd0);
        check_val("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Wakeup through the CDB, visible one cycle after the broadcast.
        insert(4'd2, 3'd4, 1'b0, 16'h0000, 3'd2, 1'b1, 16'h0005, 3'd0);
        expect_disp(4'd2, 3'd4, 16'h0010, 16'h0005);
        check_val("wake_wait_valid", {31'd0, out_valid}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h0010;
        #1;
        check_val("wake_no_comb_path", {31'd0, out_valid}, 32'd0);
        tick();
        cdb_valid = 1'b0;
        check_val("wake_valid", {31'd0, out_valid}, 32'd1);
        check_val("wake_a",     {16'd0, out_a}, 32'h0010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // CDB bypass on insert.
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'hBEEF;
        insert(4'd3, 3'd7, 1'b1, 16'h0033, 3'd0, 1'b0, 16'h0000, 3'd6);
        expect_disp(4'd3, 3'd7, 16'h0033, 16'hBEEF);
        cdb_valid = 1'b0;
        check_val("byp_valid", {31'd0, out_valid}, 32'd1);
        check_val("byp_b",     {16'd0, out_b}, 32'hBEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Age priority: the younger ready op goes first.
        insert(4'd4, 3'd5, 1'b0, 16'h0000, 3'd1, 1'b1, 16'h0055, 3'd0);
        insert(4'd5, 3'd6, 1'b1, 16'h0066, 3'd0, 1'b1, 16'h0067, 3'd0);
        expect_disp(4'd5, 3'd6, 16'h0066, 16'h0067);
        expect_disp(4'd4, 3'd5, 16'h0A11, 16'h0055);
        check_val("age_sel_rob", {29'd0, out_rob}, 32'd6);
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'hDEAD;
        tick();
        cdb_valid = 1'b0;
        check_val("age_nomatch_rob",   {29'd0, out_rob}, 32'd6);
        check_val("age_nomatch_count", {30'd0, count}, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("age_after_first_valid", {31'd0, out_valid}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h0A11;
        tick();
        cdb_valid = 1'b0;
        check_val("age_second_rob", {29'd0, out_rob}, 32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("age_done_count", {30'd0, count}, 32'd0);

        // Insert, dispatch and wakeup in one cycle, then flush with in_valid.
        insert(4'd6, 3'd1, 1'b1, 16'h0101, 3'd0, 1'b1, 16'h0102, 3'd0);
        expect_disp(4'd6, 3'd1, 16'h0101, 16'h0102);
        insert(4'd7, 3'd2, 1'b0, 16'h0000, 3'd3, 1'b1, 16'h0202, 3'd0);
        check_val("sim_pre_count", {30'd0, count}, 32'd2);
        out_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h0333;
        insert(4'd8, 3'd4, 1'b1, 16'h0401, 3'd0, 1'b1, 16'h0402, 3'd0);
        out_ready = 1'b0;
        cdb_valid = 1'b0;
        check_val("sim_count",   {30'd0, count}, 32'd2);
        check_val("sim_sel_rob", {29'd0, out_rob}, 32'd2);
        check_val("sim_sel_a",   {16'd0, out_a}, 32'h0333);
        flush = 1'b1;
        in_valid = 1'b1; in_func = 4'd9; in_rob = 3'd5;
        in_v1_rdy = 1'b1; in_v1 = 16'h0505; in_v2_rdy = 1'b1; in_v2 = 16'h0506;
        #1;
        check_val("flush_cycle_valid", {31'd0, out_valid}, 32'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("flush_count",     {30'd0, count}, 32'd0);
        check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("flush_in_ready",  {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-cycle with two busy entries.
        insert(4'd1, 3'd1, 1'b1, 16'h1111, 3'd0, 1'b1, 16'h1112, 3'd0);
        insert(4'd1, 3'd2, 1'b1, 16'h2221, 3'd0, 1'b1, 16'h2222, 3'd0);
        check_val("prerst_count", {30'd0, count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_count",     {30'd0, count}, 32'd0);
        check_val("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("arst_in_ready",  {31'd0, in_ready}, 32'd1);
        #1;
        rst = 1'b0;

        // Recovery after reset.
        insert(4'd2, 3'd3, 1'b1, 16'h3331, 3'd0, 1'b1, 16'h3332, 3'd0);
        expect_disp(4'd2, 3'd3, 16'h3331, 16'h3332);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check_val("sb_empty", sb.size(), 32'd0);
        check_val("end_count", {30'd0, count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
